// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: sizing constants shared by the reorder buffer slice
package reorder_buffer_pkg;
  localparam int ROB_ENT_NUM = 64;
  localparam int ROB_SEL = 6;
  localparam int PHY_REG_SEL = 6;
  localparam int REG_SEL = 5;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, completion and commit signals of the reorder buffer
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;
  logic flush;
  logic dp1_valid, dp2_valid, dp1_wr_reg, dp2_wr_reg;
  logic [REG_SEL-1:0] dp1_arch_dst, dp2_arch_dst;
  logic [PHY_REG_SEL-1:0] dp1_phy_dst, dp2_phy_dst, dp1_ori_dst, dp2_ori_dst;
  logic dp_ready;
  logic [ROB_SEL-1:0] rob_tag1, rob_tag2;
  logic cmpl1_valid, cmpl2_valid;
  logic [ROB_SEL-1:0] cmpl1_tag, cmpl2_tag;
  logic [1:0] comnum;
  logic [PHY_REG_SEL-1:0] released_tag1, released_tag2;
  logic released_tag1_val, released_tag2_val;
  logic [REG_SEL-1:0] com1_arch_dst, com2_arch_dst;
  logic [PHY_REG_SEL-1:0] com1_phy_dst, com2_phy_dst;
  logic [ROB_SEL:0] rob_count;
  modport master (
    output flush, dp1_valid, dp2_valid, dp1_wr_reg, dp2_wr_reg, dp1_arch_dst, dp2_arch_dst,
           dp1_phy_dst, dp2_phy_dst, dp1_ori_dst, dp2_ori_dst, cmpl1_valid, cmpl2_valid,
           cmpl1_tag, cmpl2_tag,
    input  dp_ready, rob_tag1, rob_tag2, comnum, released_tag1, released_tag2,
           released_tag1_val, released_tag2_val, com1_arch_dst, com2_arch_dst,
           com1_phy_dst, com2_phy_dst, rob_count
  );
  modport slave (
    input  flush, dp1_valid, dp2_valid, dp1_wr_reg, dp2_wr_reg, dp1_arch_dst, dp2_arch_dst,
           dp1_phy_dst, dp2_phy_dst, dp1_ori_dst, dp2_ori_dst, cmpl1_valid, cmpl2_valid,
           cmpl1_tag, cmpl2_tag,
    output dp_ready, rob_tag1, rob_tag2, comnum, released_tag1, released_tag2,
           released_tag1_val, released_tag2_val, com1_arch_dst, com2_arch_dst,
           com1_phy_dst, com2_phy_dst, rob_count
  );
endinterface

// File: rtl/reorder_buffer_commit_sel.sv
// reorder_buffer_commit_sel: in-order readiness check of the two oldest entries
module reorder_buffer_commit_sel (
  input  logic       i_valid0,
  input  logic       i_done0,
  input  logic       i_valid1,
  input  logic       i_done1,
  output logic       o_c1,
  output logic       o_c2,
  output logic [1:0] o_comnum
);
  assign o_c1 = i_valid0 & i_done0;
  assign o_c2 = o_c1 & i_valid1 & i_done1;
  assign o_comnum = {o_c2, o_c1 & ~o_c2};
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: dual-dispatch, dual-commit in-order retirement buffer
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic clk,
  input logic reset,
  reorder_buffer_if.slave rob
);
  logic [ROB_SEL:0] r_head, r_tail, r_count, w_free;
  logic [ROB_ENT_NUM-1:0] r_valid, r_done, r_wr_reg;
  logic [REG_SEL-1:0] r_arch [ROB_ENT_NUM];
  logic [PHY_REG_SEL-1:0] r_phy [ROB_ENT_NUM];
  logic [PHY_REG_SEL-1:0] r_ori [ROB_ENT_NUM];
  logic [ROB_SEL-1:0] w_h0, w_h1, w_t0, w_t1;
  logic w_ready, w_acc1, w_acc2, w_c1, w_c2;
  logic [1:0] w_comnum;
  assign w_h0 = r_head[ROB_SEL-1:0];
  assign w_h1 = w_h0 + ROB_SEL'(1);
  assign w_t0 = r_tail[ROB_SEL-1:0];
  assign w_t1 = w_t0 + ROB_SEL'(1);
  assign w_free = (ROB_SEL+1)'(ROB_ENT_NUM) - r_count;
  assign w_ready = w_free >= (ROB_SEL+1)'(2);
  // slot 2 rides only behind slot 1 so entries stay contiguous
  assign w_acc1 = w_ready & rob.dp1_valid & ~rob.flush;
  assign w_acc2 = w_acc1 & rob.dp2_valid;
  reorder_buffer_commit_sel u_sel (
    .i_valid0(r_valid[w_h0]),
    .i_done0 (r_done[w_h0]),
    .i_valid1(r_valid[w_h1]),
    .i_done1 (r_done[w_h1]),
    .o_c1    (w_c1),
    .o_c2    (w_c2),
    .o_comnum(w_comnum)
  );
  assign rob.dp_ready = w_ready;
  assign rob.rob_tag1 = w_t0;
  assign rob.rob_tag2 = w_t1;
  assign rob.rob_count = r_count;
  assign rob.comnum = rob.flush ? 2'd0 : w_comnum;
  assign rob.released_tag1 = rob.flush ? '0 : r_ori[w_h0];
  assign rob.released_tag2 = rob.flush ? '0 : r_ori[w_h1];
  assign rob.released_tag1_val = ~rob.flush & w_c1 & r_wr_reg[w_h0];
  assign rob.released_tag2_val = ~rob.flush & w_c2 & r_wr_reg[w_h1];
  assign rob.com1_arch_dst = rob.flush ? '0 : r_arch[w_h0];
  assign rob.com2_arch_dst = rob.flush ? '0 : r_arch[w_h1];
  assign rob.com1_phy_dst = rob.flush ? '0 : r_phy[w_h0];
  assign rob.com2_phy_dst = rob.flush ? '0 : r_phy[w_h1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done <= '0;
      r_wr_reg <= '0;
      for (int i = 0; i < ROB_ENT_NUM; i++) begin
        r_arch[i] <= '0;
        r_phy[i] <= '0;
        r_ori[i] <= '0;
      end
    end else if (rob.flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done <= '0;
    end else begin
      if (rob.cmpl1_valid && r_valid[rob.cmpl1_tag]) r_done[rob.cmpl1_tag] <= 1'b1;
      if (rob.cmpl2_valid && r_valid[rob.cmpl2_tag]) r_done[rob.cmpl2_tag] <= 1'b1;
      if (w_c1) begin
        r_valid[w_h0] <= 1'b0;
        r_done[w_h0] <= 1'b0;
      end
      if (w_c2) begin
        r_valid[w_h1] <= 1'b0;
        r_done[w_h1] <= 1'b0;
      end
      if (w_acc1) begin
        r_valid[w_t0] <= 1'b1;
        r_done[w_t0] <= 1'b0;
        r_wr_reg[w_t0] <= rob.dp1_wr_reg;
        r_arch[w_t0] <= rob.dp1_arch_dst;
        r_phy[w_t0] <= rob.dp1_phy_dst;
        r_ori[w_t0] <= rob.dp1_ori_dst;
      end
      if (w_acc2) begin
        r_valid[w_t1] <= 1'b1;
        r_done[w_t1] <= 1'b0;
        r_wr_reg[w_t1] <= rob.dp2_wr_reg;
        r_arch[w_t1] <= rob.dp2_arch_dst;
        r_phy[w_t1] <= rob.dp2_phy_dst;
        r_ori[w_t1] <= rob.dp2_ori_dst;
      end
      r_head <= r_head + (ROB_SEL+1)'(w_comnum);
      r_tail <= r_tail + (ROB_SEL+1)'(w_acc1) + (ROB_SEL+1)'(w_acc2);
      r_count <= r_count + (ROB_SEL+1)'(w_acc1) + (ROB_SEL+1)'(w_acc2) - (ROB_SEL+1)'(w_comnum);
    end
  end
endmodule
